// File: rtl/cacheline_adaptor.sv
// ============================================================================
// Module   : cacheline_adaptor
// Purpose  : Bridges a 256-bit cache line port to a 64-bit, 4-beat burst
//            memory interface (line fill and line write-back).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adaptor #(
    parameter int S_LINE   = 256,
    parameter int S_BURST  = 64,
    parameter int S_OFFSET = 5
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [S_LINE-1:0]   line_i,
    output logic [S_LINE-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,

    input  logic [S_BURST-1:0]  burst_i,
    output logic [S_BURST-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int S_BEATS = S_LINE / S_BURST;
    localparam int C_CW    = $clog2(S_BEATS);
    localparam logic [C_CW-1:0] C_LAST_BEAT = C_CW'(S_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [C_CW-1:0]     count_q, count_d;
    logic [S_LINE-1:0]   line_q,  line_d;
    logic [S_LINE-1:0]   buf_q,   buf_d;
    logic [31:0]         addr_q,  addr_d;
    logic [31:0]         w_addr_aligned;
    logic                w_unused;

    assign w_addr_aligned = {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
    // Byte-offset bits are deliberately dropped by the alignment above.
    assign w_unused       = ^address_i[S_OFFSET-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            line_q  <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        line_d  = line_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Write-back wins when both requests arrive together; the
                // controller keeps read_i asserted until it is serviced.
                if (write_i) begin
                    addr_d  = w_addr_aligned;
                    buf_d   = line_i;
                    count_d = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = w_addr_aligned;
                    count_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    line_d[count_q*S_BURST +: S_BURST] = burst_i;
                    count_d = count_q + C_CW'(1);
                    if (count_q == C_LAST_BEAT) state_d = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    count_d = count_q + C_CW'(1);
                    if (count_q == C_LAST_BEAT) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign line_o    = line_q;
    assign address_o = addr_q;
    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign burst_o   = (state_q == WRITE) ? buf_q[count_q*S_BURST +: S_BURST]
                                          : '0;

endmodule

`default_nettype wire
